// File: rtl/ps2_sender.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// serializes each one as an 11-slot PS/2 frame on registered ps2_clk/ps2_data.
module ps2_sender #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP         = 16,
  parameter int DEPTH       = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] PH_HALF  = PW'(HALF_PERIOD);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;

  state_t        state_q;
  logic [10:0]   shift_q;
  logic [PW-1:0] phase_q;
  logic [3:0]    slot_q;
  logic [GW-1:0] gapCnt_q;
  logic          ps2Clk_q, ps2Data_q;

  logic          push, pop;
  logic [7:0]    head;

  // in_ready looks at the count before any pop, so a full FIFO refuses a
  // byte even in the cycle the FSM drains one.
  assign in_ready = (count_q < CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign head     = mem_q[rptr_q];

  assign ps2_clk  = ps2Clk_q;
  assign ps2_data = ps2Data_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE) || (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Each slot is 2*HALF_PERIOD cycles: clock high then low, data held for the
  // whole slot so the receiver samples it on the falling edge mid-slot.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      phase_q   <= '0;
      slot_q    <= '0;
      gapCnt_q  <= '0;
      ps2Clk_q  <= 1'b1;
      ps2Data_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          ps2Clk_q  <= 1'b1;
          ps2Data_q <= 1'b1;
          if (pop) begin
            shift_q <= {1'b1, ~^head, head, 1'b0};
            phase_q <= '0;
            slot_q  <= '0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          ps2Data_q <= shift_q[0];
          ps2Clk_q  <= (phase_q < PH_HALF);
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            shift_q <= {1'b1, shift_q[10:1]};
            if (slot_q == 4'd10) begin
              gapCnt_q <= '0;
              state_q  <= S_GAP;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_GAP: begin
          ps2Clk_q  <= 1'b1;
          ps2Data_q <= 1'b1;
          if (gapCnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + 1'b1;
          end
        end
        default: begin
          ps2Clk_q  <= 1'b1;
          ps2Data_q <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_sender.sv
// Directed bench for ps2_sender: a line monitor decodes frames on ps2_clk
// falling edges and the main sequence checks them against hand-computed bytes.
`timescale 1ns/1ps
module tb_ps2_sender;

  localparam int CLK_PERIOD = 10;
  localparam int HP         = 4;
  localparam int GAPC       = 16;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       overflow;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [10:0] bits;
    time         firstFall;
    bit          spacingOk;
  } frame_t;

  frame_t frames[$];

  ps2_sender #(.HALF_PERIOD(HP), .GAP(GAPC), .DEPTH(8)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .overflow (overflow)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  // Line monitor: samples 1ns after each rising edge and collects frames.
  int          bitCnt = 0;
  logic [10:0] rxBits = '0;
  time         rxFirst = 0;
  time         rxLast = 0;
  bit          rxSpacingOk = 1'b1;
  logic        prevClk = 1'b1;

  always @(posedge clk) begin
    frame_t fr;
    #1;
    if (!clrn) begin
      bitCnt  = 0;
      prevClk = 1'b1;
    end else begin
      if (prevClk === 1'b1 && ps2_clk === 1'b0) begin
        if (bitCnt == 0) begin
          rxFirst     = $time - 1;
          rxSpacingOk = 1'b1;
        end else if ($time - rxLast != 2 * HP * CLK_PERIOD) begin
          rxSpacingOk = 1'b0;
        end
        rxLast         = $time;
        rxBits[bitCnt] = ps2_data;
        bitCnt++;
        if (bitCnt == 11) begin
          fr.bits      = rxBits;
          fr.firstFall = rxFirst;
          fr.spacingOk = rxSpacingOk;
          frames.push_back(fr);
          bitCnt = 0;
        end
      end
      prevClk = ps2_clk;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, output time pushTime);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    pushTime = $time;
  endtask

  task automatic releaseInput();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    clrn     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    frames.delete();
  endtask

  task automatic waitFrames(input int n, input int limit, input string tag);
    int cnt = 0;
    while (frames.size() < n && cnt < limit) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    checkOutput({tag, " frames arrived"}, 32'(frames.size() >= n), 32'(1));
  endtask

  task automatic checkFrame(input logic [7:0] expByte, input logic expParity, output time firstFall);
    frame_t f;
    string  tag;
    tag = $sformatf("frame %02h", expByte);
    firstFall = 0;
    checkOutput({tag, " present"}, 32'(frames.size() > 0), 32'(1));
    if (frames.size() == 0) return;
    f = frames.pop_front();
    firstFall = f.firstFall;
    checkOutput({tag, " start"}, 32'(f.bits[0]), 32'(1'b0));
    checkOutput({tag, " data"}, 32'(f.bits[8:1]), 32'(expByte));
    checkOutput({tag, " parity"}, 32'(f.bits[9]), 32'(expParity));
    checkOutput({tag, " stop"}, 32'(f.bits[10]), 32'(1'b1));
    checkOutput({tag, " slot spacing"}, 32'(f.spacingOk), 32'(1'b1));
  endtask

  // Must be entered 2ns after the rising edge that delivered the 11th fall.
  task automatic checkGap(input bit lastFrame, input string tag);
    bit linesHigh = 1'b1;
    repeat (HP - 1) @(posedge clk);
    for (int i = 0; i < GAPC; i++) begin
      @(posedge clk);
      #1;
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) linesHigh = 1'b0;
      if (i == GAPC - 2) checkOutput({tag, " busy late gap"}, 32'(busy), 32'(1'b1));
      if (i == GAPC - 1) checkOutput({tag, " busy after gap"}, 32'(busy), 32'(!lastFrame));
    end
    checkOutput({tag, " lines high in gap"}, 32'(linesHigh), 32'(1'b1));
  endtask

  initial begin
    time tPush, t0, tf1, tf2, tDummy;
    int  cnt;
    logic [7:0] parByte [4];
    logic       parExp  [4];
    logic [7:0] ovParExp;
    logic [8:0] spParExp;

    clrn     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    checkOutput("reset ps2_clk", 32'(ps2_clk), 32'(1'b1));
    checkOutput("reset ps2_data", 32'(ps2_data), 32'(1'b1));
    checkOutput("reset in_ready", 32'(in_ready), 32'(1'b1));
    checkOutput("reset busy", 32'(busy), 32'(1'b0));
    checkOutput("reset overflow", 32'(overflow), 32'(1'b0));
    @(negedge clk);
    clrn = 1'b1;

    $display("[TB] single byte 0x1C");
    applyStimulus(8'h1C, tPush);
    releaseInput();
    waitFrames(1, 200, "single");
    checkGap(1'b1, "single");
    checkFrame(8'h1C, 1'b0, tf1);
    checkOutput("single first fall latency", 32'((tf1 - tPush) / CLK_PERIOD), 32'd6);

    $display("[TB] parity corners");
    doReset();
    parByte = '{8'h00, 8'hFF, 8'hF0, 8'h01};
    parExp  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) applyStimulus(parByte[i], tDummy);
    releaseInput();
    waitFrames(4, 600, "parity");
    for (int i = 0; i < 4; i++) checkFrame(parByte[i], parExp[i], tDummy);

    $display("[TB] queue and spacing");
    doReset();
    applyStimulus(8'hF0, tDummy);
    applyStimulus(8'h1C, tDummy);
    releaseInput();
    waitFrames(1, 200, "queue1");
    checkGap(1'b0, "queue1");
    waitFrames(2, 200, "queue2");
    checkGap(1'b1, "queue2");
    checkFrame(8'hF0, 1'b1, tf1);
    checkFrame(8'h1C, 1'b0, tf2);
    checkOutput("queue start spacing", 32'((tf2 - tf1) / CLK_PERIOD), 32'd105);

    $display("[TB] overflow");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h21 + 8'(i), tDummy);
      #1;
      if (i == 8) begin
        checkOutput("ovf full in_ready", 32'(in_ready), 32'(1'b0));
        checkOutput("ovf full no flag", 32'(overflow), 32'(1'b0));
      end
    end
    checkOutput("ovf flag set", 32'(overflow), 32'(1'b1));
    checkOutput("ovf in_ready low", 32'(in_ready), 32'(1'b0));
    releaseInput();
    waitFrames(9, 1200, "ovf");
    ovParExp = 8'b0;
    // Odd parity of 0x21..0x28, bit i for byte 0x21+i; 0x29 handled below.
    ovParExp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) checkFrame(8'h21 + 8'(i), ovParExp[i], tDummy);
    checkFrame(8'h29, 1'b0, tDummy);
    repeat (200) @(posedge clk);
    #2;
    checkOutput("ovf no tenth frame", 32'(frames.size()), 32'd0);
    checkOutput("ovf flag sticky", 32'(overflow), 32'(1'b1));
    checkOutput("ovf busy drained", 32'(busy), 32'(1'b0));

    $display("[TB] full fifo with simultaneous pop");
    doReset();
    checkOutput("sim reset clears flag", 32'(overflow), 32'(1'b0));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h31 + 8'(i), tPush);
      if (i == 0) t0 = tPush;
    end
    releaseInput();
    while ($time < t0 + 1055) @(negedge clk);
    checkOutput("sim in_ready before pop", 32'(in_ready), 32'(1'b0));
    checkOutput("sim flag before pop", 32'(overflow), 32'(1'b0));
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk);
    #1;
    checkOutput("sim flag on pop edge", 32'(overflow), 32'(1'b1));
    checkOutput("sim in_ready after pop", 32'(in_ready), 32'(1'b1));
    releaseInput();
    waitFrames(9, 1300, "sim");
    spParExp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) checkFrame(8'h31 + 8'(i), spParExp[i], tDummy);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h00, tDummy);
    applyStimulus(8'h77, tDummy);
    applyStimulus(8'h66, tDummy);
    releaseInput();
    cnt = 0;
    while (bitCnt != 6 && cnt < 300) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    checkOutput("midreset reached d4", 32'(bitCnt), 32'd6);
    #3;
    clrn = 1'b0;
    #1;
    checkOutput("midreset ps2_clk", 32'(ps2_clk), 32'(1'b1));
    checkOutput("midreset ps2_data", 32'(ps2_data), 32'(1'b1));
    checkOutput("midreset busy", 32'(busy), 32'(1'b0));
    checkOutput("midreset in_ready", 32'(in_ready), 32'(1'b1));
    checkOutput("midreset overflow", 32'(overflow), 32'(1'b0));
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    frames.delete();
    repeat (150) @(posedge clk);
    #2;
    checkOutput("midreset no resumed frame", 32'(frames.size()), 32'd0);
    checkOutput("midreset idle busy", 32'(busy), 32'(1'b0));
    applyStimulus(8'h5A, tPush);
    releaseInput();
    waitFrames(1, 200, "post-reset");
    checkFrame(8'h5A, 1'b1, tf1);
    checkOutput("post-reset latency", 32'((tf1 - tPush) / CLK_PERIOD), 32'd6);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
